cndm_gt_apb_arb: RTL and testbench

Arbiter and sequencer sharing the single transceiver-control APB completer port of the 25G MAC/GT block among several APB requesters, for example a host-register bridge and an on-chip link-tuning engine. It runs in the transceiver control clock domain, ahead of the MAC's APB control input. Each transfer is granted round-robin and sequenced through APB setup and access phases. The response is returned to the winning requester, and a watchdog aborts accesses the completer never acknowledges.

---
 rtl/cndm_gt_apb_arb_pkg.sv | 23 ++
 rtl/cndm_rr_arb.sv | 47 ++++
 rtl/cndm_gt_apb_arb.sv | 206 ++++++++++++++++++++
 tb/tb_cndm_gt_apb_arb.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cndm_gt_apb_arb_pkg.sv
// Shared types and sizing helpers for the GT APB arbiter.
package cndm_gt_apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Cycles after a locked completion during which the lock holder keeps priority.
  localparam int unsigned LOCK_WIN = 4;

  // Watchdog counter width; at least one bit so TIMEOUT=0 still elaborates.
  function automatic int unsigned wdog_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

  // Requester index width; at least one bit for a single requester.
  function automatic int unsigned idx_w(input int unsigned ports);
    return (ports <= 1) ? 1 : $clog2(ports);
  endfunction

endpackage

// File: rtl/cndm_rr_arb.sv
// Round-robin grant with a registered priority pointer.
module cndm_rr_arb import cndm_gt_apb_arb_pkg::*; #(
  parameter int unsigned PORTS = 2,
  localparam int unsigned IDX_W = idx_w(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] ptr_nxt,
  input  logic             advance,
  output logic [PORTS-1:0] grant_c,
  output logic [IDX_W-1:0] grant_idx_c
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      k;

  // Pointer load when the owner reports a completion or lock lapse.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ptr_nxt;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // First requester at or after the pointer, wrapping modulo PORTS.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    k           = 0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      k = (32'(ptr_q) + i) % PORTS;
      if (!found && req[IDX_W'(k)]) begin
        found                = 1'b1;
        grant_c[IDX_W'(k)]   = 1'b1;
        grant_idx_c          = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/cndm_gt_apb_arb.sv
// Shares the GT transceiver-control APB completer among PORTS requesters:
// round-robin grant, SETUP/ACCESS sequencing, response routing and an
// access-phase watchdog. Define CNDM_GT_APB_ARB_LOCK_EN to add s_plock.
module cndm_gt_apb_arb import cndm_gt_apb_arb_pkg::*; #(
  parameter int unsigned PORTS   = 2,
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned STRB_W  = DATA_W / 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              s_psel,
  input  logic [PORTS-1:0]              s_penable,
  input  logic [PORTS-1:0]              s_pwrite,
  input  logic [PORTS-1:0][ADDR_W-1:0]  s_paddr,
  input  logic [PORTS-1:0][DATA_W-1:0]  s_pwdata,
  input  logic [PORTS-1:0][STRB_W-1:0]  s_pstrb,
`ifdef CNDM_GT_APB_ARB_LOCK_EN
  input  logic [PORTS-1:0]              s_plock,
`endif
  output logic [PORTS-1:0]              s_pready,
  output logic [PORTS-1:0][DATA_W-1:0]  s_prdata,
  output logic [PORTS-1:0]              s_pslverr,
  output logic                          m_psel,
  output logic                          m_penable,
  output logic                          m_pwrite,
  output logic [ADDR_W-1:0]             m_paddr,
  output logic [DATA_W-1:0]             m_pwdata,
  output logic [STRB_W-1:0]             m_pstrb,
  input  logic [DATA_W-1:0]             m_prdata,
  input  logic                          m_pready,
  input  logic                          m_pslverr,
  output logic                          busy,
  output logic                          timeout_evt
);

  localparam int unsigned IDX_W = idx_w(PORTS);
  localparam int unsigned CNT_W = wdog_w(TIMEOUT);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           gnt_q, gnt_d;
  logic [CNT_W-1:0]           wdog_q, wdog_d;
  logic                       m_psel_q, m_psel_d, m_penable_q, m_penable_d;
  logic                       m_pwrite_q, m_pwrite_d;
  logic [ADDR_W-1:0]          m_paddr_q, m_paddr_d;
  logic [DATA_W-1:0]          m_pwdata_q, m_pwdata_d;
  logic [STRB_W-1:0]          m_pstrb_q, m_pstrb_d;
  logic [PORTS-1:0]           s_pready_q, s_pready_d, s_pslverr_q, s_pslverr_d;
  logic [PORTS-1:0][DATA_W-1:0] s_prdata_q, s_prdata_d;
  logic                       busy_q, busy_d, timeout_evt_q, timeout_evt_d;

  logic [PORTS-1:0]           req_c, grant_oh_c;
  logic [IDX_W-1:0]           gnt_idx_c, gnt_inc_c, ptr_nxt_c;
  logic                       ptr_adv_c, wd_expire_c, lock_hold_c;
  logic                       unused_c;

  // The completing port still shows psel during its s_pready cycle; hide it.
  assign req_c       = s_psel & ~s_pready_q;
  assign gnt_inc_c   = (32'(gnt_q) >= PORTS - 1) ? IDX_W'(0) : gnt_q + 1'b1;
  assign wd_expire_c = (TIMEOUT != 0) && (wdog_q == WD_LAST);
  assign unused_c    = ^s_penable;

  cndm_rr_arb #(.PORTS(PORTS)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (req_c),
    .ptr_nxt     (ptr_nxt_c),
    .advance     (ptr_adv_c),
    .grant_c     (grant_oh_c),
    .grant_idx_c (gnt_idx_c)
  );

`ifdef CNDM_GT_APB_ARB_LOCK_EN
  localparam int unsigned LCK_W = $clog2(LOCK_WIN + 1);
  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
  // Hold off arbitration while the lock holder has not yet re-requested.
  assign lock_hold_c = (lock_cnt_q != '0) && !req_c[gnt_q];
  // Lock window register.
  always_ff @(posedge clk) begin
    if (rst) lock_cnt_q <= '0;
    else     lock_cnt_q <= lock_cnt_d;
  end
`else
  assign lock_hold_c = 1'b0;
`endif

  // Next-state, sequencing and response routing.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    wdog_d        = wdog_q;
    m_psel_d      = m_psel_q;
    m_penable_d   = m_penable_q;
    m_pwrite_d    = m_pwrite_q;
    m_paddr_d     = m_paddr_q;
    m_pwdata_d    = m_pwdata_q;
    m_pstrb_d     = m_pstrb_q;
    s_pready_d    = '0;
    s_prdata_d    = '0;
    s_pslverr_d   = '0;
    timeout_evt_d = 1'b0;
    ptr_adv_c     = 1'b0;
    ptr_nxt_c     = gnt_inc_c;
`ifdef CNDM_GT_APB_ARB_LOCK_EN
    lock_cnt_d    = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (lock_hold_c) begin
`ifdef CNDM_GT_APB_ARB_LOCK_EN
          lock_cnt_d = lock_cnt_q - 1'b1;
          if (lock_cnt_q == LCK_W'(1)) ptr_adv_c = 1'b1;
`endif
        end else if (|grant_oh_c) begin
          gnt_d      = gnt_idx_c;
          m_psel_d   = 1'b1;
          m_pwrite_d = s_pwrite[gnt_idx_c];
          m_paddr_d  = s_paddr[gnt_idx_c];
          m_pwdata_d = s_pwdata[gnt_idx_c];
          m_pstrb_d  = s_pstrb[gnt_idx_c];
          state_d    = SETUP;
`ifdef CNDM_GT_APB_ARB_LOCK_EN
          lock_cnt_d = '0;
`endif
        end
      end
      SETUP: begin
        m_penable_d = 1'b1;
        wdog_d      = '0;
        state_d     = ACCESS;
      end
      ACCESS: begin
        if (m_pready || wd_expire_c) begin
          s_pready_d[gnt_q]  = 1'b1;
          s_pslverr_d[gnt_q] = m_pready ? m_pslverr : 1'b1;
          s_prdata_d[gnt_q]  = m_pready ? m_prdata : '0;
          timeout_evt_d      = !m_pready;
          m_psel_d           = 1'b0;
          m_penable_d        = 1'b0;
          ptr_adv_c          = 1'b1;
          state_d            = IDLE;
`ifdef CNDM_GT_APB_ARB_LOCK_EN
          if (s_plock[gnt_q]) begin
            ptr_nxt_c  = gnt_q;
            lock_cnt_d = LCK_W'(LOCK_WIN);
          end
`endif
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      wdog_q        <= '0;
      m_psel_q      <= 1'b0;
      m_penable_q   <= 1'b0;
      m_pwrite_q    <= 1'b0;
      m_paddr_q     <= '0;
      m_pwdata_q    <= '0;
      m_pstrb_q     <= '0;
      s_pready_q    <= '0;
      s_prdata_q    <= '0;
      s_pslverr_q   <= '0;
      busy_q        <= 1'b0;
      timeout_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      wdog_q        <= wdog_d;
      m_psel_q      <= m_psel_d;
      m_penable_q   <= m_penable_d;
      m_pwrite_q    <= m_pwrite_d;
      m_paddr_q     <= m_paddr_d;
      m_pwdata_q    <= m_pwdata_d;
      m_pstrb_q     <= m_pstrb_d;
      s_pready_q    <= s_pready_d;
      s_prdata_q    <= s_prdata_d;
      s_pslverr_q   <= s_pslverr_d;
      busy_q        <= busy_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign m_psel      = m_psel_q;
  assign m_penable   = m_penable_q;
  assign m_pwrite    = m_pwrite_q;
  assign m_paddr     = m_paddr_q;
  assign m_pwdata    = m_pwdata_q;
  assign m_pstrb     = m_pstrb_q;
  assign s_pready    = s_pready_q;
  assign s_prdata    = s_prdata_q;
  assign s_pslverr   = s_pslverr_q;
  assign busy        = busy_q;
  assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_cndm_gt_apb_arb.sv
// Directed bench for cndm_gt_apb_arb (two requesters, 16-cycle watchdog).
module tb_cndm_gt_apb_arb;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        s_psel, s_penable, s_pwrite;
  logic [1:0][17:0]  s_paddr;
  logic [1:0][15:0]  s_pwdata;
  logic [1:0][1:0]   s_pstrb;
  logic [1:0]        s_pready, s_pslverr;
  logic [1:0][15:0]  s_prdata;
  logic              m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [17:0]       m_paddr;
  logic [15:0]       m_pwdata, m_prdata;
  logic [1:0]        m_pstrb;
  logic              busy, timeout_evt;
`ifdef CNDM_GT_APB_ARB_LOCK_EN
  logic [1:0]        s_plock;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cndm_gt_apb_arb #(.PORTS(2), .ADDR_W(18), .DATA_W(16), .STRB_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
`ifdef CNDM_GT_APB_ARB_LOCK_EN
    .s_plock(s_plock),
`endif
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .busy(busy), .timeout_evt(timeout_evt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completer side: wait for ACCESS, stall `waits` cycles, respond, check routing.
  task automatic complete(input int port, input int waits, input logic [15:0] rd,
                          input logic err, input logic [17:0] addr, input string tag);
    int         n = 0;
    logic       pb;
    logic [1:0] oh;
    pb = port[0];
    oh = 2'b01 << port;
    while (!(m_psel && m_penable) && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_access"}, 32'(m_psel && m_penable), 32'd1);
    chk({tag, "_paddr"}, 32'(m_paddr), 32'(addr));
    repeat (waits) tick();
    m_pready  = 1'b1;
    m_prdata  = rd;
    m_pslverr = err;
    tick();
    m_pready  = 1'b0;
    m_prdata  = 16'h0;
    m_pslverr = 1'b0;
    chk({tag, "_pready"}, 32'(s_pready), 32'(oh));
    chk({tag, "_prdata"}, 32'(s_prdata[pb]), 32'(rd));
    chk({tag, "_pslverr"}, 32'(s_pslverr[pb]), 32'(err));
    chk({tag, "_prdata_other"}, 32'(pb ? s_prdata[0] : s_prdata[1]), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    rst = 1'b1;
    s_psel = '0; s_penable = '0; s_pwrite = '0;
    s_paddr = '0; s_pwdata = '0; s_pstrb = '0;
    m_prdata = '0; m_pready = 1'b0; m_pslverr = 1'b0;
`ifdef CNDM_GT_APB_ARB_LOCK_EN
    s_plock = '0;
`endif
    do_reset();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_psel", 32'(m_psel), 32'd0);
    chk("rst_m_penable", 32'(m_penable), 32'd0);
    chk("rst_s_pready", 32'(s_pready), 32'd0);
    chk("rst_timeout_evt", 32'(timeout_evt), 32'd0);

    // Single write on port 0, ready on first ACCESS cycle
    s_psel = 2'b01; s_penable = 2'b01; s_pwrite = 2'b01;
    s_paddr[0] = 18'h00123; s_pwdata[0] = 16'hBEEF; s_pstrb[0] = 2'b11;
    tick();
    chk("wr_setup_psel", 32'(m_psel), 32'd1);
    chk("wr_setup_penable", 32'(m_penable), 32'd0);
    chk("wr_setup_busy", 32'(busy), 32'd1);
    chk("wr_paddr", 32'(m_paddr), 32'h00123);
    chk("wr_pwdata", 32'(m_pwdata), 32'hBEEF);
    chk("wr_pwrite", 32'(m_pwrite), 32'd1);
    chk("wr_pstrb", 32'(m_pstrb), 32'd3);
    chk("wr_setup_pready", 32'(s_pready), 32'd0);
    tick();
    chk("wr_access_psel", 32'(m_psel), 32'd1);
    chk("wr_access_penable", 32'(m_penable), 32'd1);
    m_pready = 1'b1;
    tick();
    m_pready = 1'b0;
    chk("wr_done_pready", 32'(s_pready), 32'd1);
    chk("wr_done_pslverr", 32'(s_pslverr), 32'd0);
    chk("wr_done_psel", 32'(m_psel), 32'd0);
    s_psel = '0; s_penable = '0;
    tick();
    chk("wr_after_pready", 32'(s_pready), 32'd0);
    chk("wr_after_busy", 32'(busy), 32'd0);

    // Simultaneous requests from reset alternate 0,1,0,1...
    do_reset();
    s_psel = 2'b11; s_penable = 2'b11; s_pwrite = 2'b00;
    s_paddr[0] = 18'h00100; s_paddr[1] = 18'h00200;
    for (int i = 0; i < 10; i++) begin
      complete(i % 2, 0, 16'h1000 + 16'(i), 1'b0, (i % 2 == 0) ? 18'h00100 : 18'h00200,
               $sformatf("rr%0d", i));
    end
    s_psel = '0; s_penable = '0;
    tick();
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Read on port 1 with 5 wait cycles and a completer error
    s_psel = 2'b10; s_penable = 2'b10; s_paddr[1] = 18'h00300;
    complete(1, 5, 16'h5A5A, 1'b1, 18'h00300, "rd_err");
    s_psel = '0; s_penable = '0;
    tick();
    chk("rd_err_clear_prdata", 32'(s_prdata[1]), 32'd0);
    chk("rd_err_clear_pslverr", 32'(s_pslverr), 32'd0);

    // Watchdog abort after 16 ACCESS cycles
    s_psel = 2'b01; s_penable = 2'b01; s_pwrite = 2'b01; s_paddr[0] = 18'h00400;
    m_prdata = 16'hFFFF;
    n = 0;
    while (!(m_psel && m_penable) && n < 50) begin
      tick();
      n++;
    end
    chk("to_access", 32'(m_psel && m_penable), 32'd1);
    repeat (15) tick();
    chk("to_wait_pready", 32'(s_pready), 32'd0);
    chk("to_wait_penable", 32'(m_penable), 32'd1);
    chk("to_wait_evt", 32'(timeout_evt), 32'd0);
    tick();
    chk("to_pready", 32'(s_pready), 32'd1);
    chk("to_pslverr", 32'(s_pslverr[0]), 32'd1);
    chk("to_prdata", 32'(s_prdata[0]), 32'd0);
    chk("to_evt", 32'(timeout_evt), 32'd1);
    chk("to_psel", 32'(m_psel), 32'd0);
    s_psel = '0; s_penable = '0; m_prdata = 16'h0;
    tick();
    chk("to_busy_after", 32'(busy), 32'd0);
    chk("to_evt_after", 32'(timeout_evt), 32'd0);
    chk("to_pready_after", 32'(s_pready), 32'd0);

    // Reset during ACCESS, then pointer back at 0
    s_psel = 2'b10; s_penable = 2'b10; s_paddr[1] = 18'h00500;
    n = 0;
    while (!(m_psel && m_penable) && n < 50) begin
      tick();
      n++;
    end
    chk("mid_rst_access", 32'(m_psel && m_penable), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_psel", 32'(m_psel), 32'd0);
    chk("mid_rst_penable", 32'(m_penable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pready", 32'(s_pready), 32'd0);
    rst = 1'b0;
    s_psel = 2'b11; s_penable = 2'b11; s_paddr[0] = 18'h00600;
    complete(0, 1, 16'h0600, 1'b0, 18'h00600, "post_rst0");
    complete(1, 0, 16'h0500, 1'b0, 18'h00500, "post_rst1");
    s_psel = '0; s_penable = '0;
    tick();

`ifdef CNDM_GT_APB_ARB_LOCK_EN
    // Port 1 keeps the completer for 3 transfers while port 0 waits
    do_reset();
    s_plock = 2'b10;
    s_psel = 2'b10; s_penable = 2'b10;
    s_paddr[0] = 18'h00800; s_paddr[1] = 18'h00700;
    complete(1, 0, 16'h0701, 1'b0, 18'h00700, "lock1");
    s_psel = 2'b11; s_penable = 2'b11;
    complete(1, 0, 16'h0702, 1'b0, 18'h00700, "lock2");
    s_plock = 2'b00;
    complete(1, 0, 16'h0703, 1'b0, 18'h00700, "lock3");
    complete(0, 0, 16'h0800, 1'b0, 18'h00800, "lock_rel");
    s_psel = '0; s_penable = '0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
